// File: rtl/wb_region_arbiter_if.sv
// wb_region_arbiter_if: upstream Wishbone slave pins plus the fan-out bus to the regions
interface wb_region_arbiter_if #(
    parameter int NUM_SLAVES = 2
);
    logic                    wbs_cyc_i;
    logic                    wbs_stb_i;
    logic                    wbs_we_i;
    logic [3:0]              wbs_sel_i;
    logic [31:0]             wbs_adr_i;
    logic [31:0]             wbs_dat_i;
    logic                    wbs_ack_o;
    logic [31:0]             wbs_dat_o;
    logic [NUM_SLAVES-1:0]   s_cyc_o;
    logic [NUM_SLAVES-1:0]   s_stb_o;
    logic                    s_we_o;
    logic [3:0]              s_sel_o;
    logic [31:0]             s_adr_o;
    logic [31:0]             s_dat_o;
    logic [NUM_SLAVES-1:0]   s_ack_i;
    logic [NUM_SLAVES*32-1:0] s_dat_i;
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, s_ack_i, s_dat_i,
        output wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, s_ack_i, s_dat_i,
        input  wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );
endinterface

// File: rtl/wb_region_arbiter.sv
// wb_region_arbiter: mask/base region decoder with latched selection, registered response and error termination
module wb_region_arbiter #(
    parameter int                       NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE   = {32'h3000_0000, 32'h300F_FFF8},
    parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = {32'hFFF0_0000, 32'hFFFF_FFF8},
    parameter int                       TIMEOUT    = 16,
    parameter logic [31:0]              ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    wb_region_arbiter_if.slave    bus,
    output logic                  err_o,
    output logic [15:0]           err_count_o,
    output logic [31:0]           err_addr_o
);
    localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] sel_idx, sel_nx, hit_idx;
    logic          hit, err_nx;
    logic [15:0]   cnt, cnt_nx;
    logic [31:0]   dat_nx;

    // descending scan so the lowest matching index is the one left standing
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if ((bus.wbs_adr_i & SLV_MASK[i*32 +: 32]) == (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32])) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel_idx;
        cnt_nx   = cnt;
        dat_nx   = bus.wbs_dat_o;
        err_nx   = 1'b0;
        case (state)
            IDLE:
                if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                    if (hit) begin
                        sel_nx   = hit_idx;
                        cnt_nx   = '0;
                        state_nx = BUSY;
                    end else begin
                        dat_nx   = ERR_DATA;
                        err_nx   = 1'b1;
                        state_nx = DONE;
                    end
                end
            BUSY: begin
                cnt_nx = cnt + 16'd1;
                if (!bus.wbs_cyc_i)
                    state_nx = IDLE;
                else if (bus.s_ack_i[sel_idx]) begin
                    dat_nx   = bus.s_dat_i[{sel_idx, 5'd0} +: 32];
                    state_nx = DONE;
                end else if (cnt == 16'(TIMEOUT - 1)) begin
                    dat_nx   = ERR_DATA;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state         <= IDLE;
            sel_idx       <= '0;
            cnt           <= '0;
            bus.wbs_dat_o <= '0;
            err_o         <= 1'b0;
            err_count_o   <= '0;
            err_addr_o    <= '0;
        end else begin
            state         <= state_nx;
            sel_idx       <= sel_nx;
            cnt           <= cnt_nx;
            bus.wbs_dat_o <= dat_nx;
            err_o         <= err_nx;
            if (err_nx) begin
                err_addr_o <= bus.wbs_adr_i;
                if (err_count_o != 16'hFFFF)
                    err_count_o <= err_count_o + 16'd1;
            end
        end
    end

    assign bus.wbs_ack_o = state == DONE;
    assign bus.s_cyc_o   = state == BUSY ? NUM_SLAVES'(1) << sel_idx : '0;
    assign bus.s_stb_o   = bus.s_cyc_o & {NUM_SLAVES{bus.wbs_stb_i}};
    // shared copies are gated so every output reads zero while reset is held
    assign bus.s_we_o    = bus.wbs_we_i & wb_rst_ni;
    assign bus.s_sel_o   = bus.wbs_sel_i & {4{wb_rst_ni}};
    assign bus.s_adr_o   = bus.wbs_adr_i & {32{wb_rst_ni}};
    assign bus.s_dat_o   = bus.wbs_dat_i & {32{wb_rst_ni}};
endmodule

// File: tb/tb_wb_region_arbiter.sv
// tb_wb_region_arbiter: directed checks of decode, latency, timeout, abort, saturation and reset
module tb_wb_region_arbiter;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        err_o;
    logic [15:0] err_count_o;
    logic [31:0] err_addr_o;
    int          total = 0;
    int          bad = 0;

    wb_region_arbiter_if #(.NUM_SLAVES(2)) b();

    wb_region_arbiter dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .bus         (b.slave),
        .err_o       (err_o),
        .err_count_o (err_count_o),
        .err_addr_o  (err_addr_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #2;
    endtask

    task automatic bus_idle();
        b.wbs_cyc_i = 1'b0;
        b.wbs_stb_i = 1'b0;
        b.wbs_we_i  = 1'b0;
        b.s_ack_i   = 2'b00;
    endtask

    task automatic start(input logic [31:0] adr, input logic we);
        b.wbs_cyc_i = 1'b1;
        b.wbs_stb_i = 1'b1;
        b.wbs_we_i  = we;
        b.wbs_adr_i = adr;
    endtask

    task automatic test_reset();
        bus_idle();
        b.wbs_sel_i = 4'hF;
        b.wbs_adr_i = 32'h3000_0010;
        b.wbs_dat_i = 32'h1111_2222;
        b.s_dat_i   = '0;
        wb_rst_ni   = 1'b0;
        tick();
        tick();
        total++; if (b.wbs_ack_o !== 1'b0 || b.wbs_dat_o !== 32'h0) begin bad++; $display("FAIL reset_resp got ack=%b dat=%h exp ack=0 dat=0", b.wbs_ack_o, b.wbs_dat_o); end
        total++; if (b.s_cyc_o !== 2'b00 || b.s_adr_o !== 32'h0 || b.s_dat_o !== 32'h0) begin bad++; $display("FAIL reset_fanout got cyc=%b adr=%h dat=%h exp all 0", b.s_cyc_o, b.s_adr_o, b.s_dat_o); end
        total++; if (err_o !== 1'b0 || err_count_o !== 16'h0 || err_addr_o !== 32'h0) begin bad++; $display("FAIL reset_err got err=%b cnt=%h addr=%h exp all 0", err_o, err_count_o, err_addr_o); end
        wb_rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_read_region1();
        b.s_dat_i = {32'h1234_5678, 32'hBAD0_0000};
        start(32'h3000_0010, 1'b0);
        tick();
        total++; if (b.s_cyc_o !== 2'b10 || b.s_stb_o !== 2'b10) begin bad++; $display("FAIL read_select got cyc=%b stb=%b exp 10/10", b.s_cyc_o, b.s_stb_o); end
        tick();
        tick();
        b.s_ack_i = 2'b10;
        #1;
        total++; if (b.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL read_early_ack got %b exp 0", b.wbs_ack_o); end
        tick();
        b.s_ack_i   = 2'b00;
        b.wbs_cyc_i = 1'b0;
        b.wbs_stb_i = 1'b0;
        total++; if (b.wbs_ack_o !== 1'b1 || b.wbs_dat_o !== 32'h1234_5678) begin bad++; $display("FAIL read_resp got ack=%b dat=%h exp ack=1 dat=12345678", b.wbs_ack_o, b.wbs_dat_o); end
        total++; if (b.s_cyc_o !== 2'b00 || err_o !== 1'b0 || err_count_o !== 16'd0) begin bad++; $display("FAIL read_done got cyc=%b err=%b cnt=%h exp 00/0/0", b.s_cyc_o, err_o, err_count_o); end
        tick();
        total++; if (b.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL read_ack_width got %b exp 0", b.wbs_ack_o); end
    endtask

    task automatic test_write_overlap();
        b.wbs_sel_i = 4'b0110;
        b.wbs_dat_i = 32'hA5A5_5A5A;
        start(32'h300F_FFFC, 1'b1);
        #1;
        total++; if (b.s_we_o !== 1'b1 || b.s_sel_o !== 4'b0110 || b.s_dat_o !== 32'hA5A5_5A5A || b.s_adr_o !== 32'h300F_FFFC) begin bad++; $display("FAIL write_mirror got we=%b sel=%b dat=%h adr=%h exp 1/0110/a5a55a5a/300ffffc", b.s_we_o, b.s_sel_o, b.s_dat_o, b.s_adr_o); end
        tick();
        b.s_ack_i = 2'b10;
        total++; if (b.s_cyc_o !== 2'b01) begin bad++; $display("FAIL overlap_select got %b exp 01", b.s_cyc_o); end
        tick();
        total++; if (b.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL foreign_ack got ack=%b exp 0", b.wbs_ack_o); end
        b.s_ack_i = 2'b01;
        tick();
        bus_idle();
        total++; if (b.wbs_ack_o !== 1'b1 || err_o !== 1'b0 || err_count_o !== 16'd0) begin bad++; $display("FAIL write_resp got ack=%b err=%b cnt=%h exp 1/0/0", b.wbs_ack_o, err_o, err_count_o); end
        tick();
    endtask

    task automatic test_unmapped();
        start(32'h4000_0000, 1'b0);
        tick();
        bus_idle();
        total++; if (b.wbs_ack_o !== 1'b1 || b.wbs_dat_o !== 32'hDEAD_BEEF || b.s_cyc_o !== 2'b00) begin bad++; $display("FAIL unmapped_resp got ack=%b dat=%h cyc=%b exp 1/deadbeef/00", b.wbs_ack_o, b.wbs_dat_o, b.s_cyc_o); end
        total++; if (err_o !== 1'b1 || err_count_o !== 16'd1 || err_addr_o !== 32'h4000_0000) begin bad++; $display("FAIL unmapped_err got err=%b cnt=%h addr=%h exp 1/0001/40000000", err_o, err_count_o, err_addr_o); end
        tick();
        total++; if (err_o !== 1'b0 || b.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL unmapped_pulse got err=%b ack=%b exp 0/0", err_o, b.wbs_ack_o); end
    endtask

    task automatic test_timeout();
        int n;
        start(32'h300F_FFF8, 1'b0);
        n = 1;
        do begin
            tick();
            n++;
        end while (b.wbs_ack_o !== 1'b1 && n < 40);
        bus_idle();
        total++; if (n !== 18) begin bad++; $display("FAIL timeout_latency got cycle=%0d exp 18", n); end
        total++; if (b.wbs_dat_o !== 32'hDEAD_BEEF || err_o !== 1'b1 || err_count_o !== 16'd2 || err_addr_o !== 32'h300F_FFF8) begin bad++; $display("FAIL timeout_err got dat=%h err=%b cnt=%h addr=%h exp deadbeef/1/0002/300ffff8", b.wbs_dat_o, err_o, err_count_o, err_addr_o); end
        tick();
        b.s_dat_i = {32'h0, 32'h7777_7777};
        b.s_ack_i = 2'b01;
        tick();
        b.s_ack_i = 2'b00;
        total++; if (b.wbs_ack_o !== 1'b0 || b.wbs_dat_o !== 32'hDEAD_BEEF || err_count_o !== 16'd2) begin bad++; $display("FAIL late_ack got ack=%b dat=%h cnt=%h exp 0/deadbeef/0002", b.wbs_ack_o, b.wbs_dat_o, err_count_o); end
    endtask

    task automatic test_ack_on_timeout();
        b.s_dat_i = {32'h0, 32'hCAFE_F00D};
        start(32'h300F_FFF8, 1'b0);
        repeat (16) tick();
        b.s_ack_i = 2'b01;
        tick();
        bus_idle();
        total++; if (b.wbs_ack_o !== 1'b1 || b.wbs_dat_o !== 32'hCAFE_F00D || err_o !== 1'b0 || err_count_o !== 16'd2) begin bad++; $display("FAIL ack_at_timeout got ack=%b dat=%h err=%b cnt=%h exp 1/cafef00d/0/0002", b.wbs_ack_o, b.wbs_dat_o, err_o, err_count_o); end
        tick();
    endtask

    task automatic test_abort();
        start(32'h3000_0010, 1'b0);
        repeat (5) tick();
        b.wbs_cyc_i = 1'b0;
        b.wbs_stb_i = 1'b0;
        #1;
        total++; if (b.s_cyc_o !== 2'b10 || b.s_stb_o !== 2'b00) begin bad++; $display("FAIL abort_same_cycle got cyc=%b stb=%b exp 10/00", b.s_cyc_o, b.s_stb_o); end
        tick();
        total++; if (b.s_cyc_o !== 2'b00 || b.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL abort_drop got cyc=%b ack=%b exp 00/0", b.s_cyc_o, b.wbs_ack_o); end
        tick();
        total++; if (b.wbs_ack_o !== 1'b0 || err_o !== 1'b0 || err_count_o !== 16'd2 || b.wbs_dat_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL abort_quiet got ack=%b err=%b cnt=%h dat=%h exp 0/0/0002/cafef00d", b.wbs_ack_o, err_o, err_count_o, b.wbs_dat_o); end
    endtask

    task automatic test_saturation();
        force dut.err_count_o = 16'hFFFE;
        #1;
        release dut.err_count_o;
        for (int k = 0; k < 2; k++) begin
            start(32'h5000_0004, 1'b1);
            tick();
            bus_idle();
            total++; if (err_count_o !== 16'hFFFF || err_o !== 1'b1) begin bad++; $display("FAIL saturate_%0d got cnt=%h err=%b exp ffff/1", k, err_count_o, err_o); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        b.wbs_sel_i = 4'hF;
        b.wbs_dat_i = 32'h0BAD_CAFE;
        start(32'h3000_0010, 1'b1);
        tick();
        tick();
        total++; if (b.s_cyc_o !== 2'b10) begin bad++; $display("FAIL midrst_busy got cyc=%b exp 10", b.s_cyc_o); end
        wb_rst_ni = 1'b0;
        #1;
        total++; if (b.s_cyc_o !== 2'b00 || b.s_stb_o !== 2'b00 || b.s_we_o !== 1'b0 || b.s_sel_o !== 4'h0 || b.s_adr_o !== 32'h0 || b.s_dat_o !== 32'h0) begin bad++; $display("FAIL midrst_fanout got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h exp all 0", b.s_cyc_o, b.s_stb_o, b.s_we_o, b.s_sel_o, b.s_adr_o, b.s_dat_o); end
        total++; if (b.wbs_ack_o !== 1'b0 || b.wbs_dat_o !== 32'h0 || err_o !== 1'b0 || err_count_o !== 16'h0 || err_addr_o !== 32'h0) begin bad++; $display("FAIL midrst_regs got ack=%b dat=%h err=%b cnt=%h addr=%h exp all 0", b.wbs_ack_o, b.wbs_dat_o, err_o, err_count_o, err_addr_o); end
        bus_idle();
        tick();
        wb_rst_ni = 1'b1;
        tick();
        tick();
        total++; if (b.wbs_ack_o !== 1'b0 || b.s_cyc_o !== 2'b00) begin bad++; $display("FAIL midrst_after got ack=%b cyc=%b exp 0/00", b.wbs_ack_o, b.s_cyc_o); end
    endtask

    initial begin
        test_reset();
        test_read_region1();
        test_write_overlap();
        test_unmapped();
        test_timeout();
        test_ack_on_timeout();
        test_abort();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
